// File: rtl/twpm_ram_arbiter.sv
// Single-clock arbiter for the shared TPM buffer RAM: Wishbone window vs. byte-wide DP port.
// Round-robin grant, ownership from exec checked at grant, one registered RAM port.
module twpm_ram_arbiter #(
  parameter int         RAM_ADDR_WIDTH  = 11,
  parameter logic [7:0] DENY_READ_VALUE = 8'hFF
) (
  input  logic                      wb_clk,
  input  logic                      rstn_i,
  input  logic                      exec,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  input  logic [RAM_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  input  logic                      dp_req,
  input  logic                      dp_we,
  input  logic [RAM_ADDR_WIDTH-1:0] dp_addr,
  input  logic [7:0]                dp_wdata,
  output logic [7:0]                dp_rdata,
  output logic                      dp_ack,
  output logic [RAM_ADDR_WIDTH-3:0] ram_addr,
  output logic [31:0]               ram_wd,
  output logic [3:0]                ram_wen,
  input  logic [31:0]               ram_rd,
  output logic [7:0]                deny_cnt
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_e;

  typedef struct packed {
    logic [RAM_ADDR_WIDTH-3:0] waddr;
    logic [31:0]               wd;
    logic [NUM_LANES-1:0]      wen;
  } ram_req_t;

  state_e                    state_q, state_d;
  logic                      last_dp_q, last_dp_d;   // 1: last grant went to DP
  logic                      owner_dp_q, owner_dp_d;
  logic                      deny_q, deny_d;
  logic [1:0]                lane_q, lane_d;
  logic [RAM_ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [31:0]               wd_q, wd_d;
  logic [NUM_LANES-1:0]      wen_q, wen_d;
  logic [31:0]               wb_dat_q, wb_dat_d;
  logic                      wb_ack_q, wb_ack_d;
  logic                      wb_err_q, wb_err_d;
  logic [7:0]                dp_rdata_q, dp_rdata_d;
  logic                      dp_ack_q, dp_ack_d;
  logic [7:0]                cnt_q, cnt_d;

  logic                      wb_pend, dp_pend, pick_dp, grant_deny;
  logic [NUM_LANES-1:0]      dp_lane_wen;
  ram_req_t                  wb_rq, dp_rq, sel_rq;
  logic [31:0]               rd_sh;
  logic                      unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  assign wb_pend    = wb_cyc_i & wb_stb_i & ~wb_ack_q & ~wb_err_q;
  assign dp_pend    = dp_req & ~dp_ack_q;
  assign pick_dp    = dp_pend & (~wb_pend | ~last_dp_q);
  assign grant_deny = pick_dp ? exec : ~exec;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign dp_lane_wen[i] = dp_we & (dp_addr[1:0] == 2'(i));
  end

  assign wb_rq.waddr = wb_adr_i[RAM_ADDR_WIDTH-1:2];
  assign wb_rq.wd    = wb_dat_i;
  assign wb_rq.wen   = wb_we_i ? wb_sel_i : '0;
  assign dp_rq.waddr = dp_addr[RAM_ADDR_WIDTH-1:2];
  assign dp_rq.wd    = {NUM_LANES{dp_wdata}};
  assign dp_rq.wen   = dp_lane_wen;
  assign sel_rq      = pick_dp ? dp_rq : wb_rq;
  assign rd_sh       = ram_rd >> {lane_q, 3'b000};

  always_comb begin
    state_d    = state_q;
    last_dp_d  = last_dp_q;
    owner_dp_d = owner_dp_q;
    deny_d     = deny_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    wen_d      = '0;
    wb_dat_d   = wb_dat_q;
    wb_ack_d   = 1'b0;
    wb_err_d   = 1'b0;
    dp_rdata_d = dp_rdata_q;
    dp_ack_d   = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (wb_pend | dp_pend) begin
          last_dp_d  = pick_dp;
          owner_dp_d = pick_dp;
          deny_d     = grant_deny;
          lane_d     = dp_addr[1:0];
          if (grant_deny) begin
            // Denied grants skip the RAM entirely and answer next cycle.
            state_d = RESP;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end else begin
            state_d = ACC;
            addr_d  = sel_rq.waddr;
            wd_d    = sel_rq.wd;
            wen_d   = sel_rq.wen;
          end
        end
      end
      ACC:  state_d = WAIT;
      WAIT: begin
        state_d = RESP;
        if (owner_dp_q) dp_rdata_d = rd_sh[7:0];
        else            wb_dat_d   = ram_rd;
      end
      RESP: begin
        state_d = IDLE;
        if (owner_dp_q) begin
          dp_ack_d = 1'b1;
          if (deny_q) dp_rdata_d = DENY_READ_VALUE;
        end else if (deny_q) begin
          wb_err_d = 1'b1;
        end else begin
          wb_ack_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      last_dp_q  <= 1'b1;
      owner_dp_q <= 1'b0;
      deny_q     <= 1'b0;
      lane_q     <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      wen_q      <= '0;
      wb_dat_q   <= '0;
      wb_ack_q   <= 1'b0;
      wb_err_q   <= 1'b0;
      dp_rdata_q <= '0;
      dp_ack_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dp_q  <= last_dp_d;
      owner_dp_q <= owner_dp_d;
      deny_q     <= deny_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      wen_q      <= wen_d;
      wb_dat_q   <= wb_dat_d;
      wb_ack_q   <= wb_ack_d;
      wb_err_q   <= wb_err_d;
      dp_rdata_q <= dp_rdata_d;
      dp_ack_q   <= dp_ack_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_wd   = wd_q;
  assign ram_wen  = wen_q;
  assign wb_dat_o = wb_dat_q;
  assign wb_ack_o = wb_ack_q;
  assign wb_err_o = wb_err_q;
  assign dp_rdata = dp_rdata_q;
  assign dp_ack   = dp_ack_q;
  assign deny_cnt = cnt_q;

endmodule

// File: tb/tb_twpm_ram_arbiter.sv
// Bench for twpm_ram_arbiter: directed scenarios plus random traffic against a
// transaction-level model (byte memory, ownership rule, round-robin, latencies).
module tb_twpm_ram_arbiter;

  logic        wb_clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        exec = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic [10:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        dp_req = 1'b0, dp_we = 1'b0;
  logic [10:0] dp_addr = '0;
  logic [7:0]  dp_wdata = '0;
  logic [7:0]  dp_rdata;
  logic        dp_ack;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wd;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rd;
  logic [7:0]  deny_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mem_m [0:2047] = '{default: 8'h00};
  bit         last_m = 1'b1;   // 1: last grant to DP
  int         deny_m = 0;

  // RAM stand-in: byte-write, 1-cycle synchronous read
  logic [31:0] ram_mem [0:511] = '{default: 32'h0};

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_wen[i]) ram_mem[ram_addr][i*8 +: 8] <= ram_wd[i*8 +: 8];
    ram_rd <= ram_mem[ram_addr];
  end

  twpm_ram_arbiter dut (
    .wb_clk(wb_clk), .rstn_i(rstn_i), .exec(exec),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
    .dp_rdata(dp_rdata), .dp_ack(dp_ack),
    .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_wen(ram_wen), .ram_rd(ram_rd),
    .deny_cnt(deny_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_deny();
    deny_m = (deny_m < 255) ? deny_m + 1 : 255;
  endtask

  task automatic model_wb(input bit xv, input bit we, input logic [10:0] a, input logic [3:0] sel,
                          input logic [31:0] d, output logic [31:0] rd, inout int nwen);
    int base;
    base = {a[10:2], 2'b00};
    last_m = 1'b0;
    rd = '0;
    if (!xv) model_deny();
    else begin
      if (we) begin
        for (int i = 0; i < 4; i++) if (sel[i]) mem_m[base + i] = d[i*8 +: 8];
        if (sel != 0) nwen++;
      end
      rd = {mem_m[base + 3], mem_m[base + 2], mem_m[base + 1], mem_m[base]};
    end
  endtask

  task automatic model_dp(input bit xv, input bit we, input logic [10:0] a, input logic [7:0] d,
                          output logic [7:0] rd, inout int nwen);
    last_m = 1'b1;
    if (xv) begin
      model_deny();
      rd = 8'hFF;
    end else begin
      if (we) begin
        mem_m[a] = d;
        nwen++;
      end
      rd = mem_m[a];
    end
  endtask

  // One access round: optional WB and DP requests presented on the same edge.
  task automatic run_txn(input bit xv, input bit dw, input bit wwe, input logic [10:0] wa,
                         input logic [3:0] ws, input logic [31:0] wd,
                         input bit dd, input bit dwe, input logic [10:0] da, input logic [7:0] dwd,
                         input bit early,
                         output logic [31:0] wrd, output logic [7:0] drd,
                         output logic [3:0] wen0, output logic [8:0] addr0, output logic [31:0] wd0);
    int wk, dk, exp_wk, exp_dk, nwen, exp_nwen, dwl, ddl, k;
    bit wack, werr, dp_first;
    logic [31:0] exp_wrd;
    logic [7:0]  exp_drd;
    exp_nwen = 0; exp_wk = -1; exp_dk = -1; exp_wrd = '0; exp_drd = '0;
    dp_first = dd && (!dw || !last_m);
    dwl = xv ? 3 : 1;
    ddl = xv ? 1 : 3;
    if (dp_first) begin
      model_dp(xv, dwe, da, dwd, exp_drd, exp_nwen);
      exp_dk = ddl;
      if (dw) begin
        model_wb(xv, wwe, wa, ws, wd, exp_wrd, exp_nwen);
        exp_wk = ddl + 1 + dwl;
      end
    end else begin
      model_wb(xv, wwe, wa, ws, wd, exp_wrd, exp_nwen);
      exp_wk = dwl;
      if (dd) begin
        model_dp(xv, dwe, da, dwd, exp_drd, exp_nwen);
        exp_dk = dwl + 1 + ddl;
      end
    end

    @(negedge wb_clk);
    exec = xv;
    wb_cyc_i = dw; wb_stb_i = dw; wb_we_i = wwe; wb_adr_i = wa; wb_sel_i = ws; wb_dat_i = wd;
    dp_req = dd; dp_we = dwe; dp_addr = da; dp_wdata = dwd;
    wk = -1; dk = -1; wack = 0; werr = 0; nwen = 0; k = 0;
    wrd = '0; drd = '0; wen0 = '0; addr0 = '0; wd0 = '0;
    while (((dw && wk < 0) || (dd && dk < 0)) && k < 20) begin
      @(posedge wb_clk); #1;
      if (k == 0) begin
        wen0 = ram_wen; addr0 = ram_addr; wd0 = ram_wd;
        if (early) wb_stb_i = 1'b0;
      end
      if (ram_wen != 0) nwen++;
      if (wb_ack_o || wb_err_o) begin
        if (wk < 0) wk = k;
        wack |= wb_ack_o; werr |= wb_err_o;
        wrd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if (dp_ack) begin
        if (dk < 0) dk = k;
        drd = dp_rdata;
        dp_req = 1'b0;
      end
      k++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; dp_req = 1'b0;
    if (dw) begin
      chk("wb_latency", wk, exp_wk);
      chk("wb_ack_seen", wack, xv);
      chk("wb_err_seen", werr, !xv);
      if (xv && !wwe) chk("wb_rdata", wrd, exp_wrd);
    end
    if (dd) begin
      chk("dp_latency", dk, exp_dk);
      if (xv || !dwe) chk("dp_rdata", drd, exp_drd);
    end
    chk("ram_wen_cycles", nwen, exp_nwen);
    chk("deny_cnt", deny_cnt, deny_m[7:0]);
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    repeat (2) @(negedge wb_clk);
    rstn_i = 1'b1;
    last_m = 1'b1;
    deny_m = 0;
    @(negedge wb_clk);
  endtask

  initial begin
    logic [31:0] wrd, wd0;
    logic [7:0]  drd;
    logic [3:0]  wen0;
    logic [8:0]  addr0;

    repeat (2) @(negedge wb_clk);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wd", ram_wd, 0);
    chk("rst_wb_ack", wb_ack_o, 0);
    chk("rst_wb_err", wb_err_o, 0);
    chk("rst_wb_dat", wb_dat_o, 0);
    chk("rst_dp_ack", dp_ack, 0);
    chk("rst_dp_rdata", dp_rdata, 0);
    chk("rst_deny_cnt", deny_cnt, 0);
    rstn_i = 1'b1;
    @(negedge wb_clk);

    // Tie right after reset: WB wins, DP denied afterwards
    run_txn(1, 1, 0, 11'h010, 4'hF, 0, 1, 0, 11'h011, 0, 0, wrd, drd, wen0, addr0, wd0);
    chk("t3_dp_deny_data", drd, 8'hFF);
    chk("t3_deny_one", deny_cnt, 1);
    // WB alone, then a tie goes to DP first
    run_txn(1, 1, 0, 11'h010, 4'hF, 0, 0, 0, 0, 0, 0, wrd, drd, wen0, addr0, wd0);
    run_txn(1, 1, 0, 11'h010, 4'hF, 0, 1, 0, 11'h011, 0, 0, wrd, drd, wen0, addr0, wd0);

    // WB full-word write and readback
    run_txn(1, 1, 1, 11'h004, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0, wrd, drd, wen0, addr0, wd0);
    chk("t1_wen", wen0, 4'hF);
    chk("t1_addr", addr0, 1);
    chk("t1_wd", wd0, 32'hDEADBEEF);
    run_txn(1, 1, 0, 11'h004, 4'hF, 0, 0, 0, 0, 0, 0, wrd, drd, wen0, addr0, wd0);
    chk("t1_readback", wrd, 32'hDEADBEEF);

    // DP byte write into lane 2, then DP and WB readback
    run_txn(0, 0, 0, 0, 0, 0, 1, 1, 11'h006, 8'hA5, 0, wrd, drd, wen0, addr0, wd0);
    chk("t2_wen", wen0, 4'b0100);
    chk("t2_addr", addr0, 1);
    chk("t2_wd", wd0, 32'hA5A5A5A5);
    run_txn(0, 0, 0, 0, 0, 0, 1, 0, 11'h006, 0, 0, wrd, drd, wen0, addr0, wd0);
    chk("t2_dp_read", drd, 8'hA5);
    run_txn(1, 1, 0, 11'h004, 4'hF, 0, 0, 0, 0, 0, 0, wrd, drd, wen0, addr0, wd0);
    chk("t2_wb_lane2", wrd[23:16], 8'hA5);

    // WB read while DP owns the buffer
    run_txn(0, 1, 0, 11'h004, 4'hF, 0, 0, 0, 0, 0, 0, wrd, drd, wen0, addr0, wd0);
    // WB write with no byte enables, and strobe dropped early
    run_txn(1, 1, 1, 11'h00C, 4'h0, 32'h11111111, 0, 0, 0, 0, 0, wrd, drd, wen0, addr0, wd0);
    run_txn(1, 1, 1, 11'h00C, 4'h3, 32'h2222CAFE, 0, 0, 0, 0, 1, wrd, drd, wen0, addr0, wd0);
    run_txn(1, 1, 0, 11'h00C, 4'hF, 0, 0, 0, 0, 0, 0, wrd, drd, wen0, addr0, wd0);
    chk("early_drop_data", wrd, 32'h0000CAFE);

    // Reset in ACC aborts the write with no ack
    @(negedge wb_clk);
    exec = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 11'h008;
    wb_sel_i = 4'hF; wb_dat_i = 32'h12345678;
    @(posedge wb_clk); #1;
    chk("t5_wen_acc", ram_wen, 4'hF);
    rstn_i = 1'b0;
    #1;
    chk("t5_wen_reset", ram_wen, 0);
    chk("t5_no_ack", wb_ack_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk);
    chk("t5_no_ack_hold", wb_ack_o, 0);
    rstn_i = 1'b1;
    last_m = 1'b1;
    deny_m = 0;
    @(negedge wb_clk);
    run_txn(1, 1, 0, 11'h008, 4'hF, 0, 0, 0, 0, 0, 0, wrd, drd, wen0, addr0, wd0);

    // Deny counter saturation
    for (int i = 0; i < 300; i++)
      run_txn(1, 0, 0, 0, 0, 0, 1, $urandom_range(0, 1), 11'($urandom_range(0, 31)),
              8'($urandom), 0, wrd, drd, wen0, addr0, wd0);
    chk("t6_deny_sat", deny_cnt, 8'hFF);

    // Random mixed traffic from a clean counter
    do_reset();
    for (int i = 0; i < 80; i++) begin
      bit xv, dw, dd;
      xv = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      dd = dw ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(xv, dw, 1'($urandom_range(0, 1)), {4'($urandom_range(0, 7)), 2'b00, 5'h0} >> 5 << 2,
              4'($urandom), $urandom, dd, 1'($urandom_range(0, 1)),
              11'($urandom_range(0, 31)), 8'($urandom), 0, wrd, drd, wen0, addr0, wd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
